// File: rtl/clk_gate_ctrl_if.sv
// Control-side signals of the clock gate controller.
// The system side uses the master modport and the controller uses the slave modport.
interface clk_gate_ctrl_if;
    logic       ACTIVITY;
    logic       WAKE_REQ;
    logic       FORCE_ON;
    logic       Gate_EN;
    logic       CLK_RDY;
    logic [7:0] GATE_CNT;

    modport master (
        output ACTIVITY, WAKE_REQ, FORCE_ON,
        input  Gate_EN, CLK_RDY, GATE_CNT
    );

    modport slave (
        input  ACTIVITY, WAKE_REQ, FORCE_ON,
        output Gate_EN, CLK_RDY, GATE_CNT
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Idle-driven clock gate controller: gates after IDLE_CYCLES idle samples and
// reports ready WAKE_CYCLES edges after the wake-up edge. All outputs are registered.
module clk_gate_ctrl #(
    parameter int unsigned IDLE_CYCLES = 8,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input logic           CLK,
    input logic           RST,
    clk_gate_ctrl_if.slave bus
);

    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
    localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {OFF, WAKE, ON, IDLE_WAIT} state_t;

    state_t     state, state_nxt;
    logic [7:0] idle_cnt, idle_nxt;
    logic [3:0] wake_cnt, wake_nxt;
    logic [7:0] gate_cnt, gate_cnt_nxt;
    logic       gate_en, clk_rdy;
    logic       wake;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // FORCE_ON folds into wake, so no path into OFF exists while it is high
    assign wake = bus.ACTIVITY | bus.WAKE_REQ | bus.FORCE_ON;

    always_comb begin
        state_nxt    = state;
        idle_nxt     = idle_cnt;
        wake_nxt     = wake_cnt;
        gate_cnt_nxt = gate_cnt;
        case (state)
            OFF: begin
                if (wake) begin
                    state_nxt = WAKE;
                    wake_nxt  = 4'd0;
                end
            end
            WAKE: begin
                // Settling ignores wake so a wake-up always completes into ON
                if (wake_cnt == WAKE_LAST) begin
                    state_nxt = ON;
                    wake_nxt  = 4'd0;
                end else begin
                    wake_nxt = wake_cnt + 4'd1;
                end
            end
            ON: begin
                if (wake) begin
                    idle_nxt = 8'd0;
                end else begin
                    state_nxt = IDLE_WAIT;
                    idle_nxt  = 8'd1;
                end
            end
            IDLE_WAIT: begin
                if (wake) begin
                    state_nxt = ON;
                    idle_nxt  = 8'd0;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_nxt    = OFF;
                    idle_nxt     = 8'd0;
                    gate_cnt_nxt = sat_inc(gate_cnt);
                end else begin
                    idle_nxt = idle_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = OFF;
                idle_nxt  = 8'd0;
                wake_nxt  = 4'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= OFF;
            idle_cnt <= 8'd0;
            wake_cnt <= 4'd0;
            gate_cnt <= 8'd0;
            gate_en  <= 1'b0;
            clk_rdy  <= 1'b0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
            wake_cnt <= wake_nxt;
            gate_cnt <= gate_cnt_nxt;
            gate_en  <= (state_nxt != OFF);
            clk_rdy  <= (state_nxt == ON) || (state_nxt == IDLE_WAIT);
        end
    end

    assign bus.Gate_EN  = gate_en;
    assign bus.CLK_RDY  = clk_rdy;
    assign bus.GATE_CNT = gate_cnt;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with default parameters (IDLE_CYCLES=8, WAKE_CYCLES=2).
module tb_clk_gate_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;

    clk_gate_ctrl_if bus();

    clk_gate_ctrl #(.IDLE_CYCLES(8), .WAKE_CYCLES(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        bus.ACTIVITY = 1'b0;
        bus.WAKE_REQ = 1'b0;
        bus.FORCE_ON = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.Gate_EN !== 1'b0) begin failures++; $display("FAIL reset_gate_en actual=%b required=0", bus.Gate_EN); end
        checks++;
        if (bus.CLK_RDY !== 1'b0) begin failures++; $display("FAIL reset_clk_rdy actual=%b required=0", bus.CLK_RDY); end
        checks++;
        if (bus.GATE_CNT !== 8'd0) begin failures++; $display("FAIL reset_gate_cnt actual=%0d required=0", bus.GATE_CNT); end
        RST = 1'b1;
        tick();
        checks++;
        if (bus.Gate_EN !== 1'b0) begin failures++; $display("FAIL post_reset_idle actual=%b required=0", bus.Gate_EN); end
    endtask

    task automatic test_wakeup();
        bus.ACTIVITY = 1'b1;
        tick();
        checks++;
        if (bus.Gate_EN !== 1'b1 || bus.CLK_RDY !== 1'b0) begin
            failures++; $display("FAIL wakeup_edge1 actual=%b%b required=10", bus.Gate_EN, bus.CLK_RDY);
        end
        tick();
        checks++;
        if (bus.Gate_EN !== 1'b1 || bus.CLK_RDY !== 1'b0) begin
            failures++; $display("FAIL wakeup_edge2 actual=%b%b required=10", bus.Gate_EN, bus.CLK_RDY);
        end
        tick();
        checks++;
        if (bus.Gate_EN !== 1'b1 || bus.CLK_RDY !== 1'b1) begin
            failures++; $display("FAIL wakeup_edge3 actual=%b%b required=11", bus.Gate_EN, bus.CLK_RDY);
        end
    endtask

    task automatic test_gate_off();
        bus.ACTIVITY = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (bus.Gate_EN !== 1'b1 || bus.CLK_RDY !== 1'b1) begin
                failures++; $display("FAIL gate_off_hold edge=%0d actual=%b%b required=11", i, bus.Gate_EN, bus.CLK_RDY);
            end
        end
        tick();
        exp_cnt = 1;
        checks++;
        if (bus.Gate_EN !== 1'b0 || bus.CLK_RDY !== 1'b0) begin
            failures++; $display("FAIL gate_off_edge8 actual=%b%b required=00", bus.Gate_EN, bus.CLK_RDY);
        end
        checks++;
        if (bus.GATE_CNT !== 8'(exp_cnt)) begin failures++; $display("FAIL gate_off_cnt actual=%0d required=%0d", bus.GATE_CNT, exp_cnt); end
    endtask

    task automatic idle_then_check_off(input string name, input int hold_edges);
        bus.ACTIVITY = 1'b0;
        bus.WAKE_REQ = 1'b0;
        for (int i = 1; i <= hold_edges; i++) begin
            tick();
            checks++;
            if (bus.Gate_EN !== 1'b1) begin failures++; $display("FAIL %s_hold edge=%0d actual=%b required=1", name, i, bus.Gate_EN); end
        end
        tick();
        exp_cnt++;
        checks++;
        if (bus.Gate_EN !== 1'b0 || bus.CLK_RDY !== 1'b0) begin
            failures++; $display("FAIL %s_off actual=%b%b required=00", name, bus.Gate_EN, bus.CLK_RDY);
        end
        checks++;
        if (bus.GATE_CNT !== 8'(exp_cnt)) begin failures++; $display("FAIL %s_cnt actual=%0d required=%0d", name, bus.GATE_CNT, exp_cnt); end
    endtask

    task automatic test_idle_interrupt();
        test_wakeup();
        bus.ACTIVITY = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        bus.ACTIVITY = 1'b1;
        tick();
        checks++;
        if (bus.Gate_EN !== 1'b1 || bus.CLK_RDY !== 1'b1) begin
            failures++; $display("FAIL interrupt_activity actual=%b%b required=11", bus.Gate_EN, bus.CLK_RDY);
        end
        idle_then_check_off("interrupt_restart", 7);

        test_wakeup();
        bus.ACTIVITY = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        bus.WAKE_REQ = 1'b1;
        tick();
        checks++;
        if (bus.Gate_EN !== 1'b1 || bus.CLK_RDY !== 1'b1) begin
            failures++; $display("FAIL terminal_wake_req actual=%b%b required=11", bus.Gate_EN, bus.CLK_RDY);
        end
        idle_then_check_off("after_wake_req", 7);

        // Activity for one edge only: the wake-up must still complete
        bus.ACTIVITY = 1'b1;
        tick();
        bus.ACTIVITY = 1'b0;
        checks++;
        if (bus.Gate_EN !== 1'b1 || bus.CLK_RDY !== 1'b0) begin
            failures++; $display("FAIL wake_drop_edge1 actual=%b%b required=10", bus.Gate_EN, bus.CLK_RDY);
        end
        tick();
        tick();
        checks++;
        if (bus.CLK_RDY !== 1'b1) begin failures++; $display("FAIL wake_drop_ready actual=%b required=1", bus.CLK_RDY); end
        idle_then_check_off("wake_drop", 7);
    endtask

    task automatic test_force_on();
        bus.FORCE_ON = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (bus.CLK_RDY !== 1'b1) begin failures++; $display("FAIL force_ready actual=%b required=1", bus.CLK_RDY); end
        for (int i = 1; i <= 100; i++) begin
            tick();
            checks++;
            if (bus.Gate_EN !== 1'b1) begin failures++; $display("FAIL force_hold edge=%0d actual=%b required=1", i, bus.Gate_EN); end
        end
        checks++;
        if (bus.GATE_CNT !== 8'(exp_cnt)) begin failures++; $display("FAIL force_cnt actual=%0d required=%0d", bus.GATE_CNT, exp_cnt); end
        bus.FORCE_ON = 1'b0;
        idle_then_check_off("force_release", 7);
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 260; n++) begin
            bus.ACTIVITY = 1'b1;
            tick();
            tick();
            tick();
            bus.ACTIVITY = 1'b0;
            for (int i = 0; i < 8; i++) tick();
            exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
            checks++;
            if (bus.GATE_CNT !== 8'(exp_cnt) || bus.Gate_EN !== 1'b0) begin
                failures++; $display("FAIL sat_cycle n=%0d cnt=%0d gate_en=%b required cnt=%0d gate_en=0", n, bus.GATE_CNT, bus.Gate_EN, exp_cnt);
            end
        end
        checks++;
        if (bus.GATE_CNT !== 8'd255) begin failures++; $display("FAIL sat_final actual=%0d required=255", bus.GATE_CNT); end
    endtask

    task automatic test_async_reset();
        bus.ACTIVITY = 1'b1;
        tick();
        checks++;
        if (bus.Gate_EN !== 1'b1) begin failures++; $display("FAIL areset_pre actual=%b required=1", bus.Gate_EN); end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (bus.Gate_EN !== 1'b0 || bus.CLK_RDY !== 1'b0) begin
            failures++; $display("FAIL areset_immediate actual=%b%b required=00", bus.Gate_EN, bus.CLK_RDY);
        end
        checks++;
        if (bus.GATE_CNT !== 8'd0) begin failures++; $display("FAIL areset_cnt actual=%0d required=0", bus.GATE_CNT); end
        tick();
        tick();
        checks++;
        if (bus.Gate_EN !== 1'b0) begin failures++; $display("FAIL areset_held actual=%b required=0", bus.Gate_EN); end
        RST = 1'b1;
        tick();
        checks++;
        if (bus.Gate_EN !== 1'b1 || bus.CLK_RDY !== 1'b0) begin
            failures++; $display("FAIL areset_release_edge1 actual=%b%b required=10", bus.Gate_EN, bus.CLK_RDY);
        end
        tick();
        tick();
        checks++;
        if (bus.CLK_RDY !== 1'b1 || bus.GATE_CNT !== 8'd0) begin
            failures++; $display("FAIL areset_release_ready rdy=%b cnt=%0d required rdy=1 cnt=0", bus.CLK_RDY, bus.GATE_CNT);
        end
    endtask

    initial begin
        test_reset();
        test_wakeup();
        test_gate_off();
        test_idle_interrupt();
        test_force_on();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
